img_dmem_reader: RTL and testbench

//  Reads a captured 28x28 image back out of DMEM and streams it one pixel at a time.
//  The image is 784 pixels, packed 16 pixels per 256-bit word in 49 words.

---
 rtl/img_dmem_reader.sv | 185 ++++++++++++++++++
 tb/tb_img_dmem_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_dmem_reader.sv
// img_dmem_reader: reads a 28x28 image from DMEM, 16 packed pixels per
// 256-bit word, and streams it one pixel per valid/ready handshake.
// Optional feature macro IMG_RD_PREFETCH_EN: double-buffers DMEM words so the
// next word is fetched while the current one streams, removing the
// FETCH/WAIT bubble between words.
module img_dmem_reader #(
  parameter int unsigned NUM_PIXELS   = 784,
  parameter int unsigned PXL_PER_WORD = 16,
  parameter int unsigned PXL_W        = 16,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                            CLOCK_50,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            dmem_rden,
  output logic [ADDR_W-1:0]               dmem_rdaddr,
  input  logic [PXL_PER_WORD*PXL_W-1:0]   dmem_rddata,
  output logic                            pxl_valid,
  input  logic                            pxl_ready,
  output logic [PXL_W-1:0]                pxl_data,
  output logic [9:0]                      pxl_index,
  output logic                            pxl_last
);

  localparam int unsigned WORD_W    = PXL_PER_WORD * PXL_W;
  localparam int unsigned NUM_WORDS = NUM_PIXELS / PXL_PER_WORD;
  localparam int unsigned SUB_W     = $clog2(PXL_PER_WORD);

  localparam logic [5:0]       LAST_WORD = 6'(NUM_WORDS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(PXL_PER_WORD - 1);
  localparam logic [9:0]       IDX_LAST  = 10'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         word_q, word_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [9:0]         idx_q, idx_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
`ifdef IMG_RD_PREFETCH_EN
  logic [WORD_W-1:0]  spare_q, spare_d;
  logic               pf_req_q, pf_req_d;
  logic               pf_cap_q, pf_cap_d;
`endif

  // State, counters and word buffer(s)
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      sub_q    <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
`ifdef IMG_RD_PREFETCH_EN
      spare_q  <= '0;
      pf_req_q <= 1'b0;
      pf_cap_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
`ifdef IMG_RD_PREFETCH_EN
      spare_q  <= spare_d;
      pf_req_q <= pf_req_d;
      pf_cap_q <= pf_cap_d;
`endif
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    busy        = 1'b0;
    done        = 1'b0;
    dmem_rden   = 1'b0;
    dmem_rdaddr = ADDR_W'(BASE_ADDR + 32'(word_q));
    pxl_valid   = 1'b0;
`ifdef IMG_RD_PREFETCH_EN
    spare_d     = spare_q;
    pf_req_d    = pf_req_q;
    pf_cap_d    = 1'b0;
    // Read data for a prefetch arrives one cycle after the request
    if (pf_cap_q) spare_d = dmem_rddata;
`endif

    case (state_q)
      S_IDLE: begin
        word_d = '0;
        sub_d  = '0;
        idx_d  = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        dmem_rden = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        buf_d   = dmem_rddata;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        busy      = 1'b1;
        pxl_valid = 1'b1;
`ifdef IMG_RD_PREFETCH_EN
        // One prefetch per word, issued on its first STREAM cycle
        if (!pf_req_q && (word_q < LAST_WORD)) begin
          dmem_rden   = 1'b1;
          dmem_rdaddr = ADDR_W'(BASE_ADDR + 32'(word_q) + 32'd1);
          pf_req_d    = 1'b1;
          pf_cap_d    = 1'b1;
        end
`endif
        if (pxl_ready) begin
          if (idx_q != IDX_LAST) idx_d = idx_q + 10'd1;
          if (sub_q == LAST_SUB) begin
            sub_d = '0;
            if (word_q < LAST_WORD) begin
              word_d = word_q + 6'd1;
`ifdef IMG_RD_PREFETCH_EN
              // Swap in the prefetched word and keep streaming
              buf_d    = spare_q;
              pf_req_d = 1'b0;
`else
              state_d = S_FETCH;
`endif
            end else begin
              state_d = S_DONE;
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        word_d  = '0;
        sub_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start or handshake
    if (abort) begin
      state_d = S_IDLE;
      word_d  = '0;
      sub_d   = '0;
      idx_d   = '0;
`ifdef IMG_RD_PREFETCH_EN
      pf_req_d = 1'b0;
      pf_cap_d = 1'b0;
`endif
    end
  end

  // Pixel presentation from the active word buffer
  always_comb begin
    pxl_data  = buf_q[32'(sub_q) * PXL_W +: PXL_W];
    pxl_index = idx_q;
    pxl_last  = pxl_valid && (idx_q == IDX_LAST);
  end

endmodule

// File: tb/tb_img_dmem_reader.sv
// Self-checking bench for img_dmem_reader: cycle table for the start-up
// corner cases, then full image streams against an image-array model with
// a DMEM model, ready patterns, restart, abort and mid-stream reset.
module tb_img_dmem_reader;

`ifdef IMG_RD_PREFETCH_EN
  localparam bit PF       = 1'b1;
  localparam int EXP_DONE = 787;
`else
  localparam bit PF       = 1'b0;
  localparam int EXP_DONE = 883;
`endif
  localparam int NPIX = 784;
  localparam int NWORDS = 49;

  logic         CLOCK_50 = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         busy, done, dmem_rden, pxl_valid, pxl_last;
  logic         pxl_ready = 1'b0;
  logic [6:0]   dmem_rdaddr;
  logic [255:0] dmem_rddata = '0;
  logic [15:0]  pxl_data;
  logic [9:0]   pxl_index;

  img_dmem_reader #(
    .NUM_PIXELS(784), .PXL_PER_WORD(16), .PXL_W(16), .ADDR_W(7), .BASE_ADDR(0)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .dmem_rden(dmem_rden), .dmem_rdaddr(dmem_rdaddr),
    .dmem_rddata(dmem_rddata), .pxl_valid(pxl_valid), .pxl_ready(pxl_ready),
    .pxl_data(pxl_data), .pxl_index(pxl_index), .pxl_last(pxl_last)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;

  // Image model and DMEM contents derived from it
  int           img [NPIX];
  logic [255:0] mem [128];

  // DMEM: registered read; garbage on the bus when no read was issued
  always @(posedge CLOCK_50) begin
    if (dmem_rden) dmem_rddata <= mem[dmem_rdaddr];
    else dmem_rddata <= {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_img(input bit rnd);
    for (int w = 0; w < 128; w++)
      mem[w] = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    for (int p = 0; p < NPIX; p++) begin
      img[p] = rnd ? int'($urandom_range(0, 511)) : p;
      mem[p / 16][(p % 16) * 16 +: 16] = 16'(img[p]);
    end
  endtask

  // Stream monitor state
  bit   mon_en = 1'b0;
  int   exp_idx, exp_addr, done_cnt, start_cyc, done_lat, first_lat;
  bit   seen_valid;
  bit   hold_q = 1'b0;
  logic [15:0] hold_data;
  logic [9:0]  hold_idx;

  always @(negedge CLOCK_50) begin
    if (mon_en && rst_n) begin
      if (hold_q) begin
        chk("hold_valid", 32'(pxl_valid), 32'd1);
        chk("hold_data", 32'(pxl_data), 32'(hold_data));
        chk("hold_index", 32'(pxl_index), 32'(hold_idx));
      end
      if (dmem_rden) begin
        chk("rd_addr", 32'(dmem_rdaddr), 32'(exp_addr));
        exp_addr++;
      end
      if (pxl_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_lat = cyc - start_cyc;
      end
      if (pxl_valid && pxl_ready) begin
        chk("pxl_index", 32'(pxl_index), 32'(exp_idx));
        if (exp_idx < NPIX) chk("pxl_data", 32'(pxl_data), 32'(img[exp_idx]));
        chk("pxl_last", 32'(pxl_last), 32'(exp_idx == NPIX - 1));
        exp_idx++;
      end
      if (done) begin
        done_cnt++;
        done_lat = cyc - start_cyc;
        chk("done_after_all", 32'(exp_idx), 32'(NPIX));
      end
      hold_q    = pxl_valid && !pxl_ready && !abort;
      hold_data = pxl_data;
      hold_idx  = pxl_index;
    end else begin
      hold_q = 1'b0;
    end
  end

  int cur_mode = 0;

  // Drive pxl_ready per mode, then advance one cycle
  task automatic step();
    case (cur_mode)
      0: pxl_ready = 1'b1;
      1: pxl_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: pxl_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge CLOCK_50); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rden"}, 32'(dmem_rden), 32'd0);
    chk({tag, "_addr"}, 32'(dmem_rdaddr), 32'd0);
    chk({tag, "_valid"}, 32'(pxl_valid), 32'd0);
    chk({tag, "_data"}, 32'(pxl_data), 32'd0);
    chk({tag, "_index"}, 32'(pxl_index), 32'd0);
    chk({tag, "_last"}, 32'(pxl_last), 32'd0);
  endtask

  // One image stream with optional restart / abort / reset injection
  task automatic run_stream(input int mode, input int restart_at,
                            input int abort_at, input int rst_at);
    int  budget;
    bit  fired, cut;
    cur_mode = mode;
    exp_idx = 0; exp_addr = 0; done_cnt = 0; seen_valid = 1'b0;
    first_lat = -1; done_lat = -1; fired = 1'b0; cut = 1'b0;
    mon_en = 1'b1;
    start_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 6000;
    while (done_cnt == 0 && budget > 0) begin
      if (!fired && restart_at >= 0 && exp_idx >= restart_at) begin
        fired = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
      end else if (!fired && abort_at >= 0 && exp_idx >= abort_at) begin
        fired = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(pxl_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rden", 32'(dmem_rden), 32'd0);
        repeat (5) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        cut = 1'b1;
        break;
      end else if (!fired && rst_at >= 0 && exp_idx >= rst_at) begin
        fired = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        repeat (3) begin
          step();
          chk_all_zero("rst_held");
        end
        rst_n = 1'b1;
        repeat (6) begin
          step();
          chk("post_rst_busy", 32'(busy), 32'd0);
          chk("post_rst_valid", 32'(pxl_valid), 32'd0);
          chk("post_rst_rden", 32'(dmem_rden), 32'd0);
        end
        cut = 1'b1;
        break;
      end else begin
        step();
      end
      budget--;
    end
    if (!cut) begin
      if (budget == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_timeout: no done, pixels seen %0d expected %0d", exp_idx, NPIX);
      end
      repeat (4) step();
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("pixel_count", 32'(exp_idx), 32'(NPIX));
      chk("read_count", 32'(exp_addr), 32'(NWORDS));
      chk("idle_busy", 32'(busy), 32'd0);
      if (mode == 0) begin
        chk("first_valid_lat", 32'(first_lat), 32'd3);
        chk("done_lat", 32'(done_lat), 32'(EXP_DONE));
      end
    end
    mon_en = 1'b0;
  endtask

  typedef struct {
    bit st, ab, rdy;
    bit busy, val, rden, done;
    int addr, idx;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 0,  0, 0, 0, 0,  0, 0};
    tbl[1] = '{1, 1, 0,  0, 0, 0, 0,  0, 0};  // abort beats start in IDLE
    tbl[2] = '{1, 0, 1,  1, 0, 1, 0,  0, 0};  // FETCH word 0; ready ignored
    tbl[3] = '{0, 0, 1,  1, 0, 0, 0,  0, 0};  // WAIT
    tbl[4] = '{0, 0, 0,  1, 1, PF, 0, 1, 0};  // first STREAM cycle
    tbl[5] = '{1, 0, 0,  1, 1, 0, 0,  0, 0};  // stall, start ignored
    tbl[6] = '{0, 0, 1,  1, 1, 0, 0,  0, 1};
    tbl[7] = '{0, 0, 1,  1, 1, 0, 0,  0, 2};
    tbl[8] = '{0, 1, 0,  0, 0, 0, 0,  0, 0};  // abort mid-stream
    tbl[9] = '{0, 0, 1,  0, 0, 0, 0,  0, 0};

    load_img(1'b0);
    #2;
    chk_all_zero("reset");
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    @(posedge CLOCK_50); #1;
    chk_all_zero("idle");

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      pxl_ready = tbl[i].rdy;
      @(posedge CLOCK_50); #1;
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_valid", i), 32'(pxl_valid), 32'(tbl[i].val));
      chk($sformatf("tbl%0d_rden", i), 32'(dmem_rden), 32'(tbl[i].rden));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_index", i), 32'(pxl_index), 32'(tbl[i].idx));
      if (tbl[i].rden) chk($sformatf("tbl%0d_addr", i), 32'(dmem_rdaddr), 32'(tbl[i].addr));
      if (tbl[i].val) chk($sformatf("tbl%0d_data", i), 32'(pxl_data), 32'(img[tbl[i].idx]));
    end
    start = 1'b0; abort = 1'b0; pxl_ready = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;

    run_stream(0, -1, -1, -1);   // full-rate stream, latency
    run_stream(1, -1, -1, -1);   // ready 1-0-0-1
    run_stream(0, 100, -1, -1);  // start while busy
    run_stream(0, -1, 500, -1);  // abort, restart below
    run_stream(0, -1, -1, -1);
    run_stream(1, -1, -1, 300);  // reset mid-stream
    run_stream(0, -1, -1, -1);
    load_img(1'b1);
    run_stream(2, -1, -1, -1);   // random image, random ready
    load_img(1'b1);
    run_stream(2, 37, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
